truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequencer for the 3-input minimized-logic experiments.
- Walks the inputs of a combinational function-under-test through every input combination.
- Holds each vector long enough for the gate network to settle, then samples the output y and compares it against a golden truth-table mask.
- Reports a per-minterm mismatch mask, a fail count and a pass flag. Sits between the lab top level (start button/bench) and the gate-level function module.

Parameters:
N_INPUTS, 3, number of function inputs; vector count is 2**N_INPUTS.
EXPECTED, 8'h32, golden truth table, width 2**N_INPUTS; bit i = expected y for vec == i.
SETTLE_CYCLES, 1, cycles each vector is held before y is sampled; legal range 1..15.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  begin a sweep; honoured only in IDLE.
abort  input  1  cancel a sweep in progress; synchronous.
y  input  1  output of the function under test.
vec  output  N_INPUTS  applied input vector; vec[N_INPUTS-1] drives A, vec[0] drives C.
busy  output  1  high from the cycle after start is accepted until DONE is left.
done  output  1  one-cycle pulse when a sweep completes.
pass  output  1  valid when done or later: 1 when mismatch_mask == 0.
mismatch_mask  output  2**N_INPUTS  bit i set when sampled y != EXPECTED[i].
fail_count  output  N_INPUTS+1  number of set bits in mismatch_mask.

Behaviour:
- Reset: state IDLE, vec=0, busy=0, done=0, pass=0, mismatch_mask=0, fail_count=0, settle counter=0. Reset wins over every other input, including mid-sweep.
- IDLE:
  - start=1 -> APPLY.
  - On the transition: vec=0, settle counter=0, mismatch_mask=0, fail_count=0, pass=0.
  - Without start, all outputs hold the previous sweep's results.
- APPLY:
  - vec held constant; settle counter increments each cycle.
  - When counter == SETTLE_CYCLES-1 -> SAMPLE.
- SAMPLE (one cycle):
  - y compared with EXPECTED[vec]; on mismatch, set mismatch_mask[vec] and increment fail_count.
  - If vec == 2**N_INPUTS-1 -> DONE. Otherwise vec increments, counter=0 -> APPLY.
  - vec never wraps during a sweep.
- DONE (one cycle):
  - done=1; pass = (mismatch_mask==0), using the final SAMPLE update -> IDLE.
  - busy deasserts on the cycle done is high.
- Latency: start sampled at edge 0; done high for exactly 2**N_INPUTS*(SETTLE_CYCLES+1)+1 cycles later (default 17).
- start while busy or in DONE: ignored; no restart, no effect on results.
- abort in APPLY/SAMPLE: -> IDLE next cycle; vec=0, busy=0, done not pulsed, pass=0; mismatch_mask/fail_count keep partial values.
- abort with start in IDLE: abort ignored, sweep starts.
- abort in DONE: ignored.
- y is only sampled in SAMPLE; y changes in APPLY have no effect.
- Arithmetic: fail_count saturates naturally, since its max is 2**N_INPUTS and it fits in N_INPUTS+1 bits. No overflow path.

Decomposition:
- Package de_sweep_pkg: state enum (IDLE, APPLY, SAMPLE, DONE), localparam NUM_VECTORS = 2**N_INPUTS helper, settle-counter width constant (4 bits).
- One natural sub-module: sweep_vector_counter. It holds vec plus the settle counter and takes clear/advance/settle-done. The FSM and result registers stay in truth_table_sweeper.

Test Plan:
1. Bench models y = ~B & (A|C), EXPECTED=8'h32, SETTLE_CYCLES=1; pulse start -> vec steps 0..7 each held 2 cycles, done at cycle 17, pass=1, mismatch_mask=8'h00, fail_count=0.
2. Bench models y = B&C | ~A&(B^C), EXPECTED=8'h0E -> done, pass=0, mismatch_mask=8'h80, fail_count=1.
3. y tied to 1, EXPECTED=8'h32 -> mismatch_mask=8'hCD, fail_count=5, pass=0; a second start with the correct model clears results and yields pass=1.
4. SETTLE_CYCLES=3, start held high through the whole sweep -> exactly one sweep, each vec held 4 cycles, done at cycle 33, no restart after DONE until start is seen in IDLE.
5. abort asserted while vec=3 -> next cycle IDLE, busy=0, vec=0, no done pulse, partial mismatch_mask retained. rst asserted mid-sweep at vec=5 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/de_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package de_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SAMPLE,
    ST_DONE
  } sweep_state_e;

  // Wide enough for any hold time in 1..15 cycles.
  localparam int SETTLE_W = 4;

  function automatic int num_vectors(input int n_inputs);
    return 1 << n_inputs;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Signals between the sweeper, the lab top level and the function under test.
interface truth_table_sweeper_if #(
  parameter int N_INPUTS = 3
) ();

  logic                     start;
  logic                     abort;
  logic                     y;
  logic [N_INPUTS-1:0]      vec;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic [2**N_INPUTS-1:0]   mismatch_mask;
  logic [N_INPUTS:0]        fail_count;

  modport master (
    output start, abort, y,
    input  vec, busy, done, pass, mismatch_mask, fail_count
  );

  modport slave (
    input  start, abort, y,
    output vec, busy, done, pass, mismatch_mask, fail_count
  );

endinterface

// File: rtl/sweep_vector_counter.sv
// Applied input vector plus the per-vector settle counter.
module sweep_vector_counter
  import de_sweep_pkg::*;
#(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                advance_i,
  input  logic                count_en_i,
  output logic [N_INPUTS-1:0] vec_o,
  output logic                settle_done_o
);

  logic [N_INPUTS-1:0] vec_q, vec_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  assign settle_done_o = (cnt_q == SETTLE_W'(SETTLE_CYCLES - 1));
  assign vec_o         = vec_q;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    vec_d = vec_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      vec_d = '0;
      cnt_d = '0;
    end else if (advance_i) begin
      vec_d = vec_q + N_INPUTS'(1);
      cnt_d = '0;
    end else if (count_en_i && !settle_done_o) begin
      cnt_d = cnt_q + SETTLE_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q <= '0;
      cnt_q <= '0;
    end else begin
      vec_q <= vec_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a 3-input function through all vectors, compares y to a golden mask
// and reports per-minterm mismatches, a fail count and a pass flag.
module truth_table_sweeper
  import de_sweep_pkg::*;
#(
  parameter int                     N_INPUTS      = 3,
  parameter logic [2**N_INPUTS-1:0] EXPECTED      = 8'h32,
  parameter int                     SETTLE_CYCLES = 1
) (
  input logic                   clk,
  input logic                   rst,
  truth_table_sweeper_if.slave  bus
);

  localparam int                  NUM_VECTORS = num_vectors(N_INPUTS);
  localparam logic [N_INPUTS-1:0] LAST_VEC    = N_INPUTS'(NUM_VECTORS - 1);

  sweep_state_e             state_q, state_d;
  logic [NUM_VECTORS-1:0]   mask_q, mask_d;
  logic [N_INPUTS:0]        fail_q, fail_d;
  logic                     pass_q, pass_d;
  logic                     done_q, done_d;
  logic                     clear, advance, count_en, settle_done;

  sweep_vector_counter #(
    .N_INPUTS      (N_INPUTS),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_counter (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (clear),
    .advance_i     (advance),
    .count_en_i    (count_en),
    .vec_o         (bus.vec),
    .settle_done_o (settle_done)
  );

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    clear    = 1'b0;
    advance  = 1'b0;
    count_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_APPLY;
          clear   = 1'b1;
          mask_d  = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end
      ST_APPLY, ST_SAMPLE: begin
        // Abort keeps the partial mismatch results for inspection.
        if (bus.abort) begin
          state_d = ST_IDLE;
          clear   = 1'b1;
          pass_d  = 1'b0;
        end else if (state_q == ST_APPLY) begin
          count_en = 1'b1;
          if (settle_done) state_d = ST_SAMPLE;
        end else begin
          if (bus.y != EXPECTED[bus.vec]) begin
            mask_d[bus.vec] = 1'b1;
            fail_d          = fail_q + (N_INPUTS + 1)'(1);
          end
          if (bus.vec == LAST_VEC) begin
            state_d = ST_DONE;
          end else begin
            advance = 1'b1;
            state_d = ST_APPLY;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        pass_d  = (mask_q == '0);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.mismatch_mask = mask_q;
  assign bus.fail_count    = fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: three sweeper instances with different golden masks and hold times.
module tb_truth_table_sweeper;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   mode_a;

  typedef struct packed {
    logic [2:0] vec;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] mask;
    logic [3:0] fail;
  } obs_t;

  truth_table_sweeper_if bus_a ();
  truth_table_sweeper_if bus_b ();
  truth_table_sweeper_if bus_c ();

  truth_table_sweeper #(.N_INPUTS(3), .EXPECTED(8'h32), .SETTLE_CYCLES(1))
    u_a (.clk(clk), .rst(rst), .bus(bus_a));
  truth_table_sweeper #(.N_INPUTS(3), .EXPECTED(8'h0E), .SETTLE_CYCLES(1))
    u_b (.clk(clk), .rst(rst), .bus(bus_b));
  truth_table_sweeper #(.N_INPUTS(3), .EXPECTED(8'h32), .SETTLE_CYCLES(3))
    u_c (.clk(clk), .rst(rst), .bus(bus_c));

  // Gate-level functions under test; vec[2]=A, vec[1]=B, vec[0]=C.
  function automatic logic f_good(input logic [2:0] v);
    return ~v[1] & (v[2] | v[0]);
  endfunction

  function automatic logic f_alt(input logic [2:0] v);
    return (v[1] & v[0]) | (~v[2] & (v[1] ^ v[0]));
  endfunction

  assign bus_a.y = (mode_a == 1) ? 1'b1 : f_good(bus_a.vec);
  assign bus_b.y = f_alt(bus_b.vec);
  assign bus_c.y = f_good(bus_c.vec);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t observe(input int w);
    obs_t o;
    case (w)
      0:       o = {bus_a.vec, bus_a.busy, bus_a.done, bus_a.pass, bus_a.mismatch_mask, bus_a.fail_count};
      1:       o = {bus_b.vec, bus_b.busy, bus_b.done, bus_b.pass, bus_b.mismatch_mask, bus_b.fail_count};
      default: o = {bus_c.vec, bus_c.busy, bus_c.done, bus_c.pass, bus_c.mismatch_mask, bus_c.fail_count};
    endcase
    return o;
  endfunction

  task automatic set_ctrl(input int w, input logic start, input logic abort);
    case (w)
      0:       begin bus_a.start = start; bus_a.abort = abort; end
      1:       begin bus_b.start = start; bus_b.abort = abort; end
      default: begin bus_c.start = start; bus_c.abort = abort; end
    endcase
  endtask

  // Starts a sweep, checks the vector stepping, and returns once done pulses.
  task automatic sweep(input int w, input int per, input int exp_edges, input bit hold_start);
    obs_t o;
    int   n;
    bit   got;
    set_ctrl(w, 1'b1, 1'b0);
    tick();
    if (!hold_start) set_ctrl(w, 1'b0, 1'b0);
    o = observe(w);
    check("start_busy", 32'(o.busy), 32'd1);
    check("start_cleared", {o.vec, o.pass, o.mask, o.fail}, 32'd0);
    n   = 0;
    got = 1'b0;
    while (n < 200 && !got) begin
      tick();
      n++;
      o = observe(w);
      if (o.done) got = 1'b1;
      else if (n < 8 * per) check("vec_step", 32'(o.vec), 32'(n / per));
    end
    check("done_latency", n, exp_edges);
    check("busy_at_done", 32'(o.busy), 32'd0);
  endtask

  initial begin
    obs_t o;
    n_checks = 0;
    n_fail   = 0;
    mode_a   = 0;
    rst      = 1'b1;
    for (int w = 0; w < 3; w++) set_ctrl(w, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int w = 0; w < 3; w++) check("reset_state", observe(w), 32'd0);

    // 1: correct function, default hold.
    sweep(0, 2, 17, 1'b0);
    o = observe(0);
    check("t1_pass", 32'(o.pass), 32'd1);
    check("t1_mask", 32'(o.mask), 32'h00);
    check("t1_fail", 32'(o.fail), 32'd0);
    tick();
    o = observe(0);
    check("t1_done_pulse", 32'(o.done), 32'd0);
    check("t1_results_hold", {o.pass, o.mask, o.fail}, {23'd0, 1'b1, 8'h00, 4'd0});

    // 2: alternate function against 8'h0E; only minterm 7 disagrees.
    sweep(1, 2, 17, 1'b0);
    o = observe(1);
    check("t2_pass", 32'(o.pass), 32'd0);
    check("t2_mask", 32'(o.mask), 32'h80);
    check("t2_fail", 32'(o.fail), 32'd1);
    // abort while in DONE is ignored.
    set_ctrl(1, 1'b1, 1'b0);
    tick();
    set_ctrl(1, 1'b0, 1'b0);
    repeat (16) tick();
    set_ctrl(1, 1'b0, 1'b1);
    tick();
    set_ctrl(1, 1'b0, 1'b0);
    o = observe(1);
    check("t2_abort_in_done", 32'(o.done), 32'd1);
    check("t2_abort_in_done_mask", 32'(o.mask), 32'h80);

    // 3: y stuck high, then rerun with the correct function.
    mode_a = 1;
    sweep(0, 2, 17, 1'b0);
    o = observe(0);
    check("t3_pass", 32'(o.pass), 32'd0);
    check("t3_mask", 32'(o.mask), 32'hCD);
    check("t3_fail", 32'(o.fail), 32'd5);
    mode_a = 0;
    sweep(0, 2, 17, 1'b0);
    o = observe(0);
    check("t3_rerun_pass", 32'(o.pass), 32'd1);
    check("t3_rerun_mask", 32'(o.mask), 32'h00);

    // 4: long hold, start held high through the sweep.
    sweep(2, 4, 33, 1'b1);
    o = observe(2);
    check("t4_pass", 32'(o.pass), 32'd1);
    set_ctrl(2, 1'b0, 1'b0);
    tick();
    o = observe(2);
    check("t4_no_restart", 32'(o.busy), 32'd0);
    check("t4_done_once", 32'(o.done), 32'd0);

    // 5: abort at vec=3 with y stuck high, then reset at vec=5.
    mode_a = 1;
    set_ctrl(0, 1'b1, 1'b0);
    tick();
    set_ctrl(0, 1'b0, 1'b0);
    repeat (6) tick();
    check("t5_vec_before_abort", 32'(observe(0).vec), 32'd3);
    set_ctrl(0, 1'b0, 1'b1);
    tick();
    set_ctrl(0, 1'b0, 1'b0);
    o = observe(0);
    check("t5_abort_idle", {o.vec, o.busy, o.done, o.pass}, 32'd0);
    check("t5_abort_mask", 32'(o.mask), 32'h05);
    check("t5_abort_fail", 32'(o.fail), 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_done", 32'(observe(0).done), 32'd0);
    end
    set_ctrl(0, 1'b1, 1'b1);
    tick();
    set_ctrl(0, 1'b0, 1'b0);
    o = observe(0);
    check("t5_start_beats_abort", 32'(o.busy), 32'd1);
    repeat (10) tick();
    check("t5_vec_before_reset", 32'(observe(0).vec), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_reset_midsweep", observe(0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
